// File: rtl/cdb_rr_arbiter_pkg.sv
// Shared types for the CDB round-robin arbiter slice.
// DATA is the payload word broadcast on the common data bus.
package cdb_rr_arbiter_pkg;

    localparam int DATA_W = 32;

    typedef logic [DATA_W-1:0] DATA;

endpackage

// File: rtl/cdb_rr_arbiter_rr_pick.sv
// Purpose: round-robin pick of the first requester after the one-hot 'last' pointer.
// Latency: combinational, 0 cycles.
// Backpressure: none; caller gates the pick.
module rr_pick #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] req,
    input  logic [WIDTH-1:0] last,
    output logic [WIDTH-1:0] pick
);

    logic [WIDTH-1:0] above;
    logic [WIDTH-1:0] hi_req;
    logic [WIDTH-1:0] pool;

    // Bits strictly above 'last'; empty when last is the top bit, so the search wraps to 0.
    assign above  = ~((last << 1) - WIDTH'(1));
    assign hi_req = req & above;
    assign pool   = (|hi_req) ? hi_req : req;
    assign pick   = pool & (~pool + WIDTH'(1));

endmodule

// File: rtl/onehot_mux.sv
// Purpose: select one of WIDTH words with a one-hot (or all-zero) select vector.
// Latency: combinational, 0 cycles. An all-zero select yields zero.
// Backpressure: none; pure datapath.
module onehot_mux #(
    parameter int SIZE  = 32,
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0][SIZE-1:0] in,
    input  logic [WIDTH-1:0]           select,
    output logic [SIZE-1:0]            out
);

    always_comb begin
        out = '0;
        for (int i = 0; i < WIDTH; i++) begin
            out = out | (in[i] & {SIZE{select[i]}});
        end
    end

endmodule

// File: rtl/cdb_rr_arbiter.sv
// Purpose: round-robin share of one registered CDB slot among WIDTH requesters.
// Latency: grant in cycle n appears on out_* in cycle n+1; one word per cycle.
// Backpressure: stall holds a valid output word and suppresses grant; an empty slot still grants.
module cdb_rr_arbiter
    import cdb_rr_arbiter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          req,
    input  DATA  [WIDTH-1:0]          in,
    input  logic                      stall,
    output logic [WIDTH-1:0]          grant,
    output logic                      out_valid,
    output logic [$clog2(WIDTH)-1:0]  out_src,
    output DATA                       out_data
);

    localparam int SRC_W = $clog2(WIDTH);

    logic [WIDTH-1:0] last;
    logic [WIDTH-1:0] pick;
    logic             accept;
    DATA              mux_dat;
    logic [SRC_W-1:0] grant_idx;

    assign accept = !out_valid || !stall;
    // Held low during reset so nobody sees an acknowledge that the registers will drop.
    assign grant  = pick & {WIDTH{accept & reset}};

    rr_pick #(
        .WIDTH (WIDTH)
    ) u_pick (
        .req   (req),
        .last  (last),
        .pick  (pick)
    );

    onehot_mux #(
        .SIZE   ($bits(DATA)),
        .WIDTH  (WIDTH)
    ) u_mux (
        .in     (in),
        .select (grant),
        .out    (mux_dat)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (grant[i]) begin
                grant_idx = grant_idx | i[SRC_W-1:0];
            end
        end
    end

    // Pointer moves only on a grant, so idle and stalled cycles keep priority where it was.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last      <= WIDTH'(1) << (WIDTH - 1);
            out_valid <= 1'b0;
            out_src   <= '0;
            out_data  <= '0;
        end else if (accept) begin
            if (|grant) begin
                out_valid <= 1'b1;
                out_data  <= mux_dat;
                out_src   <= grant_idx;
                last      <= grant;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_rr_arbiter.sv
// Directed and random stimulus for cdb_rr_arbiter with a reference model and output scoreboard.
module tb_cdb_rr_arbiter;
    import cdb_rr_arbiter_pkg::*;

    logic       clock;
    logic       reset;
    logic [3:0] req;
    DATA  [3:0] in_arr;
    logic       stall;
    logic [3:0] grant;
    logic       out_valid;
    logic [1:0] out_src;
    DATA        out_data;

    int errors = 0;
    int checks = 0;

    int          m_last;
    logic        m_valid;
    logic [1:0]  m_src;
    DATA         m_data;
    logic [33:0] exp_q[$];

    cdb_rr_arbiter #(.WIDTH(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .in        (in_arr),
        .stall     (stall),
        .grant     (grant),
        .out_valid (out_valid),
        .out_src   (out_src),
        .out_data  (out_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_last  = 3;
        m_valid = 1'b0;
        m_src   = 2'd0;
        m_data  = '0;
        exp_q.delete();
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
    task automatic step(input logic [3:0] r, input logic s);
        int          gi;
        int          idx;
        logic        acc;
        logic [3:0]  eg;
        logic [33:0] e;
        req   = r;
        stall = s;
        acc   = !m_valid || !s;
        gi    = -1;
        if (acc) begin
            for (int k = 1; k <= 4; k++) begin
                idx = (m_last + k) % 4;
                if (r[idx] && gi < 0) gi = idx;
            end
        end
        eg = (gi >= 0) ? (4'b0001 << gi) : 4'b0000;
        if (gi >= 0) begin
            exp_q.push_back({gi[1:0], in_arr[gi]});
            m_last  = gi;
            m_valid = 1'b1;
        end else if (acc) begin
            m_valid = 1'b0;
        end
        #3;
        chk("grant", 64'(grant), 64'(eg));
        @(posedge clock);
        #1;
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        if (gi >= 0) begin
            e      = exp_q.pop_front();
            m_src  = e[33:32];
            m_data = e[31:0];
        end
        if (m_valid) begin
            chk("out_src", 64'(out_src), 64'(m_src));
            chk("out_data", 64'(out_data), 64'(m_data));
        end
    endtask

    initial begin
        reset     = 1'b0;
        req       = 4'b1111;
        stall     = 1'b0;
        in_arr[0] = 32'hA000_0000;
        in_arr[1] = 32'hA111_1111;
        in_arr[2] = 32'hA222_2222;
        in_arr[3] = 32'hA333_3333;
        model_reset();

        // Reset state
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_src", 64'(out_src), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_grant", 64'(grant), 64'd0);
        req = 4'b0000;
        @(posedge clock);
        #1;
        reset = 1'b1;

        // All requesting, no stall: 0,1,2,3,0,1,2,3
        for (int n = 0; n < 8; n++) step(4'b1111, 1'b0);

        // Asynchronous reset while a word is held
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_out_src", 64'(out_src), 64'd0);
        chk("arst_out_data", 64'(out_data), 64'd0);
        chk("arst_grant", 64'(grant), 64'd0);
        req = 4'b0000;
        @(posedge clock);
        #1;
        reset = 1'b1;
        model_reset();
        step(4'b1111, 1'b0);

        // Rotation and wrap-around from last = 0010
        step(4'b0010, 1'b0);
        step(4'b0011, 1'b0);
        step(4'b0010, 1'b0);

        // Stall hold on a full register
        in_arr[2] = 32'hDEADBEEF;
        step(4'b0100, 1'b0);
        for (int n = 0; n < 3; n++) step(4'b1111, 1'b1);
        step(4'b1111, 1'b0);

        // Stall with an empty register still grants
        step(4'b0000, 1'b0);
        step(4'b0100, 1'b1);
        step(4'b0000, 1'b0);

        // Idle cycles leave the pointer alone
        step(4'b0010, 1'b0);
        for (int n = 0; n < 3; n++) step(4'b0000, 1'b0);
        step(4'b1111, 1'b0);

        // Random traffic and stalls
        for (int n = 0; n < 60; n++) begin
            for (int j = 0; j < 4; j++) in_arr[j] = $urandom;
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
